// File: rtl/gcd_engine.sv
// Handshaked GCD engine: binary (Stein) or subtractive (Euclid) reduction selected per job,
// with a saturating count of the compute cycles each job used.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int CYC_W = 16
) (
   input  logic             clk_i,
   input  logic             nreset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] gcd_o,
   output logic [CYC_W-1:0] cycles_o
);

   localparam int K_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STRIP  = 3'd1,
      S_REDUCE = 3'd2,
      S_SUB    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] a_r, a_nxt_s;
   logic [WIDTH-1:0] b_r, b_nxt_s;
   logic [K_W-1:0]   k_r, k_nxt_s;
   logic [CYC_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
   logic [WIDTH-1:0] gcd_r, gcd_nxt_s;
   logic [CYC_W-1:0] cyc_r, cyc_nxt_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] diff_ab_s;
   logic [WIDTH-1:0] diff_ba_s;
   logic             a_gt_b_s;
   logic             a_eq_b_s;

   // Shared arithmetic: the difference is only ever consumed larger-minus-smaller.
   always_comb begin
      diff_ab_s = a_r - b_r;
      diff_ba_s = b_r - a_r;
      a_gt_b_s  = (a_r > b_r);
      a_eq_b_s  = (a_r == b_r);
      if (cnt_r == {CYC_W{1'b1}}) begin
         cnt_inc_s = cnt_r;
      end else begin
         cnt_inc_s = cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
      end
   end

   // Next-state and datapath update for every state.
   always_comb begin
      state_nxt_s = state_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      k_nxt_s     = k_r;
      cnt_nxt_s   = cnt_r;
      gcd_nxt_s   = gcd_r;
      cyc_nxt_s   = cyc_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid_i) begin
               a_nxt_s   = operand_a_i;
               b_nxt_s   = operand_b_i;
               k_nxt_s   = {K_W{1'b0}};
               cnt_nxt_s = {CYC_W{1'b0}};
               if (~|operand_a_i || ~|operand_b_i) begin
                  gcd_nxt_s   = operand_a_i | operand_b_i;
                  cyc_nxt_s   = {CYC_W{1'b0}};
                  state_nxt_s = S_DONE;
               end else if (mode_i) begin
                  state_nxt_s = S_SUB;
               end else begin
                  state_nxt_s = S_STRIP;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_STRIP: begin
            cnt_nxt_s = cnt_inc_s;
            if (!a_r[0] && !b_r[0]) begin
               a_nxt_s = {1'b0, a_r[WIDTH-1:1]};
               b_nxt_s = {1'b0, b_r[WIDTH-1:1]};
               k_nxt_s = k_r + {{(K_W-1){1'b0}}, 1'b1};
            end else begin
               state_nxt_s = S_REDUCE;
            end
         end
         S_REDUCE: begin
            cnt_nxt_s = cnt_inc_s;
            if (a_eq_b_s) begin
               // Restore the common power of two removed while stripping.
               gcd_nxt_s   = a_r << k_r;
               cyc_nxt_s   = cnt_inc_s;
               state_nxt_s = S_DONE;
            end else if (!a_r[0]) begin
               a_nxt_s = {1'b0, a_r[WIDTH-1:1]};
            end else if (!b_r[0]) begin
               b_nxt_s = {1'b0, b_r[WIDTH-1:1]};
            end else if (a_gt_b_s) begin
               a_nxt_s = {1'b0, diff_ab_s[WIDTH-1:1]};
            end else begin
               b_nxt_s = {1'b0, diff_ba_s[WIDTH-1:1]};
            end
         end
         S_SUB: begin
            cnt_nxt_s = cnt_inc_s;
            if (a_eq_b_s) begin
               gcd_nxt_s   = a_r;
               cyc_nxt_s   = cnt_inc_s;
               state_nxt_s = S_DONE;
            end else if (a_gt_b_s) begin
               a_nxt_s = diff_ab_s;
            end else begin
               b_nxt_s = diff_ba_s;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_r     <= S_IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         k_r         <= {K_W{1'b0}};
         cnt_r       <= {CYC_W{1'b0}};
         gcd_r       <= {WIDTH{1'b0}};
         cyc_r       <= {CYC_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         a_r         <= a_nxt_s;
         b_r         <= b_nxt_s;
         k_r         <= k_nxt_s;
         cnt_r       <= cnt_nxt_s;
         gcd_r       <= gcd_nxt_s;
         cyc_r       <= cyc_nxt_s;
         in_ready_r  <= (state_nxt_s == S_IDLE);
         out_valid_r <= (state_nxt_s == S_DONE);
      end
   end

   assign in_ready_o  = in_ready_r;
   assign out_valid_o = out_valid_r;
   assign gcd_o       = gcd_r;
   assign cycles_o    = cyc_r;

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised, handshaked GCD engine for unsigned operands. It succeeds the fixed-flow subtractive GCD datapath/controller pair with a single self-contained block. The block adds a valid/ready operand and result interface, a runtime choice between binary (Stein) and subtractive (Euclid) algorithms, and a per-job compute-cycle count. It sits behind a bus/CSR adapter or another datapath that streams operand pairs.

## Interface
- WIDTH, 16, operand and result width in bits (>= 2)
- CYC_W, 16, width of the compute-cycle counter (saturating)

- clk_i  in  1  clock, rising edge
- nreset_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  engine can accept a job
- operand_a_i  in  WIDTH  operand A, unsigned
- operand_b_i  in  WIDTH  operand B, unsigned
- mode_i  in  1  0 = binary (Stein), 1 = subtractive; sampled at accept
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer takes result
- gcd_o  out  WIDTH  GCD result
- cycles_o  out  CYC_W  compute cycles used by this job

## Operation
- States: IDLE, STRIP, REDUCE, SUB, DONE.
- in_ready_o = (state == IDLE).
- Accept occurs on a rising edge with in_valid_i && in_ready_o. At accept: register a, b, mode; k = 0; cycle counter = 0.
- Zero case at accept (a == 0 or b == 0): gcd = a | b, so gcd(0,0) = 0. Go straight to DONE with cycles = 0.
- Otherwise: mode 0 goes to STRIP, mode 1 goes to SUB.
- STRIP, one step per cycle:
  - If a and b are both even: a >>= 1, b >>= 1, k++.
  - Otherwise go to REDUCE.
- REDUCE, one step per cycle, first matching rule applies:
  - a == b: result = a << k, go to DONE.
  - a even: a >>= 1.
  - b even: b >>= 1.
  - a > b: a = (a - b) >> 1.
  - else: b = (b - a) >> 1.
- SUB, one step per cycle:
  - a == b: result = a, go to DONE.
  - a > b: a = a - b.
  - else: b = b - a.
- Every cycle spent in STRIP, REDUCE or SUB increments the counter, including the terminating cycle. The counter saturates at 2^CYC_W - 1.
- Arithmetic:
  - Subtraction is WIDTH-bit unsigned and is only ever performed on the larger minus the smaller operand (no borrow).
  - k is $clog2(WIDTH+1) bits.
  - a << k never overflows WIDTH, because the original operands were divisible by 2^k.
- DONE:
  - out_valid_o = 1; gcd_o and cycles_o are held stable.
  - When out_ready_i = 1 on an edge, go to IDLE. in_ready_o rises the following cycle; there is no same-cycle re-accept.
- in_valid_i and operand/mode changes while not in IDLE are ignored; the captured job is unaffected.
- out_ready_i outside DONE is ignored.

## Timing
- Reset values: in_ready_o = 1 (IDLE), out_valid_o = 0, gcd_o = 0, cycles_o = 0. Internal a, b, k and counter are 0.
- Reset asserted mid-job aborts the job immediately (asynchronous). No result is produced; the engine is in IDLE on deassertion.
- Latency: out_valid_o rises exactly cycles_o rising edges after the accept edge. For the zero case it is visible immediately after the accept edge.
- Worst case, binary: at most 2*WIDTH + 1 compute cycles.
- Worst case, subtractive: up to 2^WIDTH - 1 compute cycles; the counter saturates if CYC_W is too small, but the result is still correct.
- gcd_o and cycles_o change only on the transition into DONE; they otherwise hold the last result.
- Throughput: one job per (cycles + 2) edges minimum, with out_ready_i tied high.

## Test plan
- Reset: hold nreset_i low -> in_ready_o = 1, out_valid_o = 0, gcd_o = 0, cycles_o = 0. Pulse nreset_i low during REDUCE -> IDLE, no out_valid_o.
- Binary, WIDTH = 16: a = 12, b = 18, mode 0 -> gcd_o = 6, cycles_o = 5, out_valid_o 5 edges after accept. a = 1, b = 255 -> gcd_o = 1, cycles_o = 9.
- Subtractive: a = 12, b = 18, mode 1 -> gcd_o = 6, cycles_o = 3. a = 7, b = 7 -> gcd_o = 7, cycles_o = 1.
- Zero operands: (0, 42) -> 42; (42, 0) -> 42; (0, 0) -> 0. All have cycles_o = 0, out_valid_o right after accept, in both modes.
- Backpressure: hold out_ready_i = 0 for 10 cycles in DONE while toggling operands and in_valid_i -> gcd_o/cycles_o stable, in_ready_o = 0. Release -> IDLE next edge, in_ready_o = 1.
- Random: 10k random pairs in both modes against a software GCD. Check the binary-mode cycle count against a reference model. Check CYC_W = 4 saturates at 15 for a = 1, b = 65535 in mode 1, with gcd_o = 1.
